// File: rtl/wb_retire_tracer.sv
// Retirement trace capture for the RV12 writeback stage: tags each retiring
// instruction with a sequence number, buffers it and streams it out over valid/ready.
module wb_retire_tracer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic                   ret_valid_i,
  input  logic [XLEN-1:0]        ret_pc_i,
  input  logic [31:0]            ret_instr_i,
  input  logic [4:0]             ret_rd_i,
  input  logic                   ret_we_i,
  input  logic [XLEN-1:0]        ret_wdata_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [SEQ_W-1:0]       trace_seq_o,
  output logic [XLEN-1:0]        trace_pc_o,
  output logic [31:0]            trace_instr_o,
  output logic [4:0]             trace_rd_o,
  output logic                   trace_we_o,
  output logic [XLEN-1:0]        trace_wdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_W-1:0]      drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [31:0]      instr;
    logic [4:0]       rd;
    logic             we;
    logic [XLEN-1:0]  wdata;
  } rec_t;

  rec_t              mem [DEPTH];
  rec_t              new_rec;
  rec_t              head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [SEQ_W-1:0]  seq;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;
  logic we_eff;

  // Clear wins over everything in the same cycle, including the retirement itself.
  assign we_eff   = ret_we_i & (ret_rd_i != 5'd0);
  assign push_req = en_i & ret_valid_i & ~clr_i;
  assign pop      = (level != '0) & trace_ready_i & ~clr_i;
  assign full     = (level == FULL_LEVEL);
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    new_rec       = '0;
    new_rec.seq   = seq;
    new_rec.pc    = ret_pc_i;
    new_rec.instr = ret_instr_i;
    new_rec.we    = we_eff;
    new_rec.rd    = we_eff ? ret_rd_i : 5'd0;
    new_rec.wdata = we_eff ? ret_wdata_i : '0;
  end

  // Storage carries no reset; the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push_req) begin
        seq <= seq + SEQ_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Drops are never hidden: sticky flag plus a saturating count.
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    trace_valid_o = (level != '0);
    trace_seq_o   = '0;
    trace_pc_o    = '0;
    trace_instr_o = '0;
    trace_rd_o    = '0;
    trace_we_o    = 1'b0;
    trace_wdata_o = '0;
    if (trace_valid_o) begin
      trace_seq_o   = head.seq;
      trace_pc_o    = head.pc;
      trace_instr_o = head.instr;
      trace_rd_o    = head.rd;
      trace_we_o    = head.we;
      trace_wdata_o = head.wdata;
    end
  end

  assign level_o    = level;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: doc/wb_retire_tracer.md
Name: wb_retire_tracer

Overview:
Retirement trace capture block that sits directly downstream of the RV12 core's writeback stage. It samples every retiring instruction (pc, instruction word, destination register, write data, write enable) and tags it with a sequence number. Records are buffered in a FIFO and streamed out over a valid/ready interface to a trace sink or checker. Overflow is detected and counted, never silently hidden.

Parameters:
XLEN, 32, data/pc width
DEPTH, 8, FIFO entries; power of two, >= 2
SEQ_W, 16, sequence counter width
DROP_W, 8, drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
en_i  in  1  capture enable; retirements ignored when low (not counted, no seq increment)
clr_i  in  1  synchronous clear of FIFO, seq, overflow, drop count
ret_valid_i  in  1  one instruction retires this cycle (non-bubble WB)
ret_pc_i  in  XLEN  pc of retiring instruction
ret_instr_i  in  32  instruction word
ret_rd_i  in  5  destination register index
ret_we_i  in  1  register write enable from WB
ret_wdata_i  in  XLEN  write-back value
trace_valid_o  out  1  record available
trace_ready_i  in  1  sink accepts record
trace_seq_o  out  SEQ_W  sequence number
trace_pc_o  out  XLEN  pc
trace_instr_o  out  32  instruction
trace_rd_o  out  5  rd (0 when no write)
trace_we_o  out  1  effective write (ret_we & rd!=0)
trace_wdata_o  out  XLEN  write data (0 when no write)
level_o  out  clog2(DEPTH)+1  current FIFO occupancy
overflow_o  out  1  sticky: at least one record dropped
drop_cnt_o  out  DROP_W  dropped records, saturating

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. All outputs 0 in reset; FIFO empty, seq=0, overflow_o=0, drop_cnt_o=0.
- Capture: push when en_i & ret_valid_i & !clr_i. Record = {seq, pc, instr, rd_eff, we_eff, wdata_eff}; we_eff = ret_we_i & (ret_rd_i!=0); when we_eff=0, rd_eff=0 and wdata_eff=0.
- Sequence: seq increments by 1 (mod 2^SEQ_W, wraps) on every captured retirement, including dropped ones, so gaps in trace_seq_o expose drops.
- Pop: handshake completes when trace_valid_o & trace_ready_i at a rising edge.
- Output registers: head of FIFO presented directly; latency push-to-trace_valid_o = 1 cycle (record pushed at edge N visible after edge N). trace_valid_o = (level_o != 0).
- Stability: while trace_valid_o & !trace_ready_i, all trace_* outputs held constant.
- Full: push when level_o==DEPTH and no pop in same cycle -> record dropped, overflow_o set, drop_cnt_o += 1 saturating at 2^DROP_W-1. Push and pop same cycle when full -> both succeed, no drop, level unchanged.
- Empty: pop impossible (valid low); trace_ready_i ignored.
- Simultaneous push/pop when non-full: level unchanged, order preserved.
- Pointers wrap mod DEPTH; level_o never exceeds DEPTH.
- clr_i: takes effect at next edge, priority over any same-cycle push or pop; FIFO emptied, seq=0, overflow_o=0, drop_cnt_o=0. The same-cycle retirement is discarded and not counted.
- en_i low: FIFO continues to drain; no push, no seq change.
- Reset mid-stream: everything cleared immediately (asynchronous), no partial record emitted afterwards.

Test Plan:
- Single retire pc=0x200, instr=0x00F57513 (andi x10,x10,15), rd=10, we=1, wdata=0x5, ready=1 -> one cycle later valid=1, seq=0, rd=10, we=1, wdata=0x5, level=1, popped next edge.
- Retire rd=0, we=1, wdata=0xDEAD -> trace_we_o=0, trace_rd_o=0, trace_wdata_o=0.
- ready=0, 10 back-to-back retires with DEPTH=8 -> level=8, overflow_o=1, drop_cnt_o=2; then ready=1 drains seq 0..7 in order, payload stable while stalled; next retire gets seq=10.
- Full FIFO with ready=1 and retire in same cycle -> no drop, level stays 8, drop_cnt_o unchanged.
- Assert clr_i with 3 entries queued, overflow=1, and a same-cycle retire -> next cycle level=0, valid=0, overflow=0, drop_cnt=0; next captured record has seq=0.
- Drive rst_n low while valid=1 and level=5 -> valid=0, level=0 immediately; after release first record seq=0.
